tree_walker: RTL and testbench

Parametrised decision-tree inference engine. It accepts one sample of N_ATTR unsigned attributes, then walks an oblique tree held in an external synchronous node memory. At each node it evaluates a signed dot product against a threshold, follows the left or right child, and returns the class found at the leaf. It is the generalised successor of the fixed three-attribute walker: attribute count, widths and depth are parameters, both sides use valid/ready handshakes, and a runaway walk can be trapped.

---
 rtl/tree_walker_pkg.sv | 44 ++++
 rtl/tree_mac.sv | 38 +++
 rtl/tree_walker.sv | 168 ++++++++++++++++
 tb/tb_tree_walker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_walker_pkg.sv
// Shared types and layout helpers for the oblique decision-tree walker.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package tree_walker_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_MAC,
        S_DECIDE,
        S_DONE
    } state_t;

    // Accumulator wide enough for N_ATTR products of (unsigned attr) x (signed coef).
    function automatic int acc_width(input int attr_w, input int coef_w, input int n_attr);
        return attr_w + coef_w + 1 + $clog2(n_attr);
    endfunction

    function automatic int node_width(input int n_attr, input int coef_w, input int acc_w,
                                      input int node_addr_w);
        return n_attr * coef_w + acc_w + 2 * (node_addr_w + 1);
    endfunction

    // Node word, LSB first: coefficients, threshold, right child, left child.
    function automatic int thr_off(input int n_attr, input int coef_w);
        return n_attr * coef_w;
    endfunction

    function automatic int right_off(input int n_attr, input int coef_w, input int acc_w);
        return thr_off(n_attr, coef_w) + acc_w;
    endfunction

    function automatic int left_off(input int n_attr, input int coef_w, input int acc_w,
                                    input int node_addr_w);
        return right_off(n_attr, coef_w, acc_w) + node_addr_w + 1;
    endfunction

    // Child field: the bit above the address marks a leaf.
    function automatic int leaf_bit(input int node_addr_w);
        return node_addr_w;
    endfunction

endpackage

// File: rtl/tree_mac.sv
// Signed sequential multiply-accumulate: acc += zero-extended attr * signed coef.
// Latency: one cycle per term; clr zeroes acc on the next edge (clr wins over en).
// Backpressure: none, driven purely by clr/en from the walker FSM.
// Ports: clk, rst (async active-low), clr, en, attr (unsigned), coef (signed), acc (signed).
module tree_mac #(
    parameter int ATTR_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [ATTR_W-1:0]       attr,
    input  logic [COEF_W-1:0]       coef,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] attr_ext;
    logic signed [ACC_W-1:0] coef_ext;
    logic signed [ACC_W-1:0] prod;

    // Both operands extended to full accumulator width; the product always fits.
    assign attr_ext = {{(ACC_W-ATTR_W){1'b0}}, attr};
    assign coef_ext = {{(ACC_W-COEF_W){coef[COEF_W-1]}}, coef};
    assign prod     = attr_ext * coef_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod;
        end
    end

endmodule

// File: rtl/tree_walker.sv
// Oblique decision-tree inference: walks an external node memory and returns the leaf class.
// Latency: d*(N_ATTR+3) cycles from accept to out_valid for leaf depth d.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst (async active-low); in_valid/in_ready/in_attr sample input;
//        node_re/node_addr/node_rdata synchronous node memory (data one cycle after node_re);
//        out_valid/out_ready/out_class/out_depth/out_err result.
// Option: define TREE_WALKER_DEPTH_GUARD_EN to trap walks exceeding MAX_DEPTH nodes.
module tree_walker
    import tree_walker_pkg::*;
#(
    parameter int N_ATTR      = 4,
    parameter int ATTR_W      = 8,
    parameter int COEF_W      = 8,
    parameter int NODE_ADDR_W = 8,
    parameter int CLASS_W     = 8,
    parameter int ROOT_ADDR   = 0,
    parameter int MAX_DEPTH   = 16,
    localparam int ACC_W      = acc_width(ATTR_W, COEF_W, N_ATTR),
    localparam int NODE_W     = node_width(N_ATTR, COEF_W, ACC_W, NODE_ADDR_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_ATTR*ATTR_W-1:0] in_attr,
    output logic                     node_re,
    output logic [NODE_ADDR_W-1:0]   node_addr,
    input  logic [NODE_W-1:0]        node_rdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic [NODE_ADDR_W-1:0]   out_depth,
    output logic                     out_err
);

    localparam int IDX_W   = $clog2(N_ATTR);
    localparam int THR_OFF = thr_off(N_ATTR, COEF_W);
    localparam int R_OFF   = right_off(N_ATTR, COEF_W, ACC_W);
    localparam int L_OFF   = left_off(N_ATTR, COEF_W, ACC_W, NODE_ADDR_W);
    localparam int LEAF    = leaf_bit(NODE_ADDR_W);

    state_t                   state, next;
    logic [N_ATTR*ATTR_W-1:0] attr_q;
    logic [NODE_W-1:0]        node_q;
    logic [NODE_ADDR_W-1:0]   addr;
    logic [NODE_ADDR_W-1:0]   depth;
    logic [IDX_W-1:0]         idx;
    logic [CLASS_W-1:0]       cls;
    logic                     err;
    logic                     mac_clr, mac_en, last_term;
    logic signed [ACC_W-1:0]  acc, thr;
    logic [NODE_ADDR_W:0]     child;
    logic                     go_left, child_leaf, trip;

    tree_mac #(.ATTR_W(ATTR_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) u_mac (
        .clk  (clk),
        .rst  (rst),
        .clr  (mac_clr),
        .en   (mac_en),
        .attr (attr_q[idx*ATTR_W +: ATTR_W]),
        .coef (node_q[idx*COEF_W +: COEF_W]),
        .acc  (acc)
    );

    assign last_term  = (idx == IDX_W'(N_ATTR - 1));
    assign thr        = node_q[THR_OFF +: ACC_W];
    assign go_left    = (acc <= thr);
    assign child      = go_left ? node_q[L_OFF +: NODE_ADDR_W+1] : node_q[R_OFF +: NODE_ADDR_W+1];
    assign child_leaf = child[LEAF];

`ifdef TREE_WALKER_DEPTH_GUARD_EN
    // depth already counts the current node, so this fires on the node after MAX_DEPTH.
    assign trip = !child_leaf && (depth == NODE_ADDR_W'(MAX_DEPTH));
`else
    logic unused_max_depth;
    assign unused_max_depth = (MAX_DEPTH != 0);
    assign trip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next;
    end

    always_comb begin
        next      = state;
        in_ready  = 1'b0;
        node_re   = 1'b0;
        out_valid = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        case (state)
            S_IDLE: begin
                // Held low while reset is asserted even though the state is already IDLE.
                in_ready = rst;
                if (in_valid) next = S_FETCH;
            end
            S_FETCH: begin
                node_re = 1'b1;
                next    = S_WAIT;
            end
            S_WAIT: begin
                mac_clr = 1'b1;
                next    = S_MAC;
            end
            S_MAC: begin
                mac_en = 1'b1;
                if (last_term) next = S_DECIDE;
            end
            S_DECIDE: begin
                next = (child_leaf || trip) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) next = S_IDLE;
            end
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            attr_q <= '0;
            node_q <= '0;
            addr   <= NODE_ADDR_W'(ROOT_ADDR);
            depth  <= '0;
            idx    <= '0;
            cls    <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        attr_q <= in_attr;
                        addr   <= NODE_ADDR_W'(ROOT_ADDR);
                        depth  <= '0;
                        err    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    node_q <= node_rdata;
                    depth  <= depth + 1'b1;
                    idx    <= '0;
                end
                S_MAC: begin
                    if (!last_term) idx <= idx + 1'b1;
                end
                S_DECIDE: begin
                    if (trip) begin
                        cls <= '0;
                        err <= 1'b1;
                    end else if (child_leaf) begin
                        cls <= child[CLASS_W-1:0];
                    end else begin
                        addr <= child[NODE_ADDR_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign node_addr = addr;
    assign out_class = cls;
    assign out_depth = depth;
    assign out_err   = err;

endmodule

// File: tb/tb_tree_walker.sv
// Directed bench for tree_walker with default parameters and a synchronous node memory model.
// Latency: checks exact accept-to-out_valid edge counts.
// Backpressure: exercises out_ready held low and in_valid ignored outside IDLE.
module tb_tree_walker;

    localparam int NODE_W = 69;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_attr;
    logic          node_re;
    logic [7:0]    node_addr;
    logic [NODE_W-1:0] node_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_class;
    logic [7:0]    out_depth;
    logic          out_err;

    int checks = 0;
    int errors = 0;
    int re_cnt = 0;
    int dbl_re = 0;
    logic prev_re = 1'b0;

    logic [NODE_W-1:0] mem [0:255];

    tree_walker dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_attr    (in_attr),
        .node_re    (node_re),
        .node_addr  (node_addr),
        .node_rdata (node_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_depth  (out_depth),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (node_re) node_rdata <= mem[node_addr];
    end

    always @(posedge clk) begin
        if (node_re) re_cnt <= re_cnt + 1;
        if (node_re && prev_re) dbl_re <= dbl_re + 1;
        prev_re <= node_re;
    end

    function automatic logic [8:0] leaf(input logic [7:0] c);
        return {1'b1, c};
    endfunction

    function automatic logic [8:0] nd(input logic [7:0] a);
        return {1'b0, a};
    endfunction

    function automatic logic [NODE_W-1:0] mk(input logic [7:0] c0, input logic [7:0] c1,
                                             input logic [7:0] c2, input logic [7:0] c3,
                                             input logic [18:0] thr,
                                             input logic [8:0] right, input logic [8:0] left);
        return {left, right, thr, c3, c2, c1, c0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at #1 after an edge; returns at #1 after the accepting edge.
    task automatic send(input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] a2, input logic [7:0] a3);
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        in_attr  = {a3, a2, a1, a0};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("ready_after_accept", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic wait_out(output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (!out_valid && cnt < 300);
        if (!out_valid) cnt = 999;
    endtask

    task automatic result(input string tag, input int lat, input logic [7:0] cls,
                          input logic [7:0] dep, input logic e);
        int n;
        wait_out(n);
        check({tag, "_latency"}, n, lat);
        check({tag, "_class"}, {24'd0, out_class}, {24'd0, cls});
        check({tag, "_depth"}, {24'd0, out_depth}, {24'd0, dep});
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, e});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int base;
        int n;
        logic seen;

        clk = 1'b0;
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_attr = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = mk(8'sd1, 8'sd1, 8'sd1, 8'sd1, 19'sd100, nd(8'd1), leaf(8'd7));
        mem[1] = mk(8'sd2, 8'sd0, 8'sd0, -8'sd1, 19'sd0, leaf(8'd9), leaf(8'd3));

        // Reset values
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_node_re", {31'd0, node_re}, 32'd0);
        check("rst_node_addr", {24'd0, node_addr}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_class", {24'd0, out_class}, 32'd0);
        check("rst_out_depth", {24'd0, out_depth}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Leaf at root: sum 100 <= 100 goes left
        base = re_cnt;
        send(8'd10, 8'd20, 8'd30, 8'd40);
        result("t1", 7, 8'd7, 8'd1, 1'b0);
        check("t1_reads", re_cnt - base, 1);

        // Sum 101 goes right to node 1: 20-41 = -21 <= 0 goes left
        base = re_cnt;
        send(8'd10, 8'd20, 8'd30, 8'd41);
        result("t2", 14, 8'd3, 8'd2, 1'b0);
        check("t2_reads", re_cnt - base, 2);

        // Output backpressure with a competing sample offered
        send(8'd10, 8'd20, 8'd30, 8'd40);
        wait_out(n);
        check("bp_latency", n, 7);
        in_attr  = {8'd41, 8'd30, 8'd20, 8'd10};
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_class", {24'd0, out_class}, 32'd7);
            check("bp_depth", {24'd0, out_depth}, 32'd1);
            check("bp_err", {31'd0, out_err}, 32'd0);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accepted", {31'd0, in_ready}, 32'd0);
        result("bp_next", 14, 8'd3, 8'd2, 1'b0);

        // Extremes: acc = 4*255*(-128) = -130560
        mem[0] = mk(8'h80, 8'h80, 8'h80, 8'h80, -19'sd130560, leaf(8'hAA), leaf(8'h55));
        send(8'd255, 8'd255, 8'd255, 8'd255);
        result("ext_eq", 7, 8'h55, 8'd1, 1'b0);
        mem[0] = mk(8'h80, 8'h80, 8'h80, 8'h80, -19'sd130561, leaf(8'hAA), leaf(8'h55));
        send(8'd255, 8'd255, 8'd255, 8'd255);
        result("ext_gt", 7, 8'hAA, 8'd1, 1'b0);

        // Self-looping node: runaway walk
        mem[0] = mk(8'sd0, 8'sd0, 8'sd0, 8'sd0, 19'sd0, nd(8'd0), nd(8'd0));
        send(8'd1, 8'd2, 8'd3, 8'd4);
`ifdef TREE_WALKER_DEPTH_GUARD_EN
        result("guard", 112, 8'd0, 8'd16, 1'b1);
`else
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (out_valid || out_err) seen = 1'b1;
        end
        check("noguard_no_result", {31'd0, seen}, 32'd0);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
`endif
        mem[0] = mk(8'sd1, 8'sd1, 8'sd1, 8'sd1, 19'sd100, nd(8'd1), leaf(8'd7));

        // Reset during MAC of node 1 aborts the walk
        send(8'd10, 8'd20, 8'd30, 8'd41);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("abort_in_ready", {31'd0, in_ready}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_node_re", {31'd0, node_re}, 32'd0);
        check("abort_node_addr", {24'd0, node_addr}, 32'd0);
        check("abort_depth", {24'd0, out_depth}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_release_ready", {31'd0, in_ready}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_output", {31'd0, seen}, 32'd0);
        send(8'd10, 8'd20, 8'd30, 8'd41);
        result("after_abort", 14, 8'd3, 8'd2, 1'b0);

        check("node_re_single_pulse", dbl_re, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
